// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: a start request clears the MAC, streams len operand reads, then captures Cout.
// Optional abort input enabled by defining MAC_DOT_SEQ_ABORT_EN.
module mac_dot_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 8,
    parameter int LEN_W      = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef MAC_DOT_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic                    mac_clr,
    output logic                    mac_en,
    input  logic [DATA_WIDTH*3-1:0] mac_cout,
    output logic [DATA_WIDTH*3-1:0] result
);

    // Handshake: start is a level request accepted only in IDLE; done pulses for one cycle
    // and result is valid from that cycle until the next done.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    phase_q, phase_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        remain_q, remain_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    rd_en_q, rd_en_d;
    logic                    mac_clr_q, mac_clr_d;
    logic                    mac_en_q, mac_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH*3-1:0] result_q, result_d;
    logic                    abort_req;

`ifdef MAC_DOT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        base_d    = base_q;
        len_d     = len_q;
        remain_d  = remain_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = 1'b0;
        mac_clr_d = 1'b0;
        // Buffers have one cycle of read latency, so En trails the read strobe by one cycle.
        mac_en_d  = rd_en_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    len_d     = len;
                    mac_clr_d = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (len_q == '0) begin
                    result_d = '0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q;
                    remain_d  = len_q - LEN_W'(1);
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (remain_q == '0) begin
                    phase_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    remain_d  = remain_q - LEN_W'(1);
                end
            end
            S_DRAIN: begin
                // Second drain cycle: the MAC has absorbed the final product.
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    result_d = mac_cout;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_req && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            rd_en_d   = 1'b0;
            mac_en_d  = 1'b0;
            mac_clr_d = 1'b0;
            done_d    = 1'b0;
            result_d  = result_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            remain_q  <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            base_q    <= base_d;
            len_q     <= len_d;
            remain_q  <= remain_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            mac_clr_q <= mac_clr_d;
            mac_en_q  <= mac_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign mac_clr = mac_clr_q;
    assign mac_en  = mac_en_q;
    assign result  = result_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: models the two operand buffers and the MAC, predicts the dot product
// arithmetically, and checks cycle-exact control timing; abort tests need MAC_DOT_SEQ_ABORT_EN.
module tb_mac_dot_seq;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int LW = 9;
    localparam int RW = DW * 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort_drv;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy, done, rd_en, mac_clr, mac_en;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] mac_cout;
    logic [RW-1:0] result;

    int vectors     = 0;
    int miscompares = 0;
    logic [RW-1:0] exp_result = '0;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] rd_a = '0;
    logic [DW-1:0] rd_b = '0;
    logic [RW-1:0] acc  = '0;

    always #5 clk = ~clk;

    mac_dot_seq #(.DATA_WIDTH(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MAC_DOT_SEQ_ABORT_EN
        .abort     (abort_drv),
`endif
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_cout  (mac_cout),
        .result    (result)
    );

    // Operand buffers (1-cycle read latency) and MAC accumulator.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
        end
        if (mac_clr)
            acc <= '0;
        else if (mac_en)
            acc <= acc + ({16'b0, rd_a} * {16'b0, rd_b});
    end
    assign mac_cout = acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] ref_dot(input int b, input int l);
        longint sum = 0;
        for (int i = 0; i < l; i++) begin
            int idx = (b + i) % 256;
            sum += longint'(mem_a[idx]) * longint'(mem_b[idx]);
        end
        return RW'(sum % (longint'(1) << RW));
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = DW'($urandom_range(0, 255));
            mem_b[i] = DW'($urandom_range(0, 255));
        end
    endtask

    // Runs one job with start seen in cycle 0 and checks every cycle up to done.
    task automatic run_job(input int b, input int l, input bit hold);
        int last;
        logic [RW-1:0] want;
        want = ref_dot(b, l);
        last = (l == 0) ? 2 : l + 4;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        start     = 1'b1;
        base_addr = AW'(b);
        len       = LW'(l);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            abort_drv = 1'b0;
            check("busy", 32'(busy), 1);
            check("mac_clr", 32'(mac_clr), 32'(c == 1));
            check("rd_en", 32'(rd_en), 32'(c >= 2 && c <= l + 1));
            if (c >= 2 && c <= l + 1)
                check("rd_addr", 32'(rd_addr), 32'((b + c - 2) % 256));
            check("mac_en", 32'(mac_en), 32'(c >= 3 && c <= l + 2));
            check("done", 32'(done), 32'(c == last));
            check("result", 32'(result), 32'((c == last) ? want : exp_result));
        end
        exp_result = want;
    endtask

    task automatic check_quiet(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check("quiet_busy", 32'(busy), 0);
            check("quiet_done", 32'(done), 0);
            check("quiet_result", 32'(result), 32'(exp_result));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort_drv = 1'b0; base_addr = '0; len = '0;
        fill_random();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_mac_clr", 32'(mac_clr), 0);
        check("rst_mac_en", 32'(mac_en), 0);
        check("rst_result", 32'(result), 0);
        rst_n = 1'b1;

        // Directed: 1..4 . 5..8 = 70
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = DW'(i + 5);
        end
        run_job(0, 4, 1'b0);
        check("t1_value", 32'(result), 70);

        // Zero length
        run_job(0, 0, 1'b0);
        check_quiet(2);

        // Address wrap with maximum operands: 3 * 255 * 255 = 195075
        mem_a[254] = 8'hff; mem_b[254] = 8'hff;
        mem_a[255] = 8'hff; mem_b[255] = 8'hff;
        mem_a[0]   = 8'hff; mem_b[0]   = 8'hff;
        run_job(254, 3, 1'b0);
        check("t3_value", 32'(result), 195075);

        // start held high for a whole job, then accepted the cycle after done
        fill_random();
        run_job(40, 5, 1'b1);
        run_job(100, 2, 1'b0);
        check_quiet(2);

        // Synchronous reset during RUN
        @(negedge clk);
        start = 1'b1; base_addr = 8'd10; len = 9'd10;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_result = '0;
        check("rr_busy", 32'(busy), 0);
        check("rr_rd_en", 32'(rd_en), 0);
        check("rr_mac_en", 32'(mac_en), 0);
        check("rr_rd_addr", 32'(rd_addr), 0);
        check("rr_result", 32'(result), 0);
        check_quiet(14);
        run_job(7, 6, 1'b0);

`ifdef MAC_DOT_SEQ_ABORT_EN
        // Abort in RUN: back to IDLE, no done, result held
        @(negedge clk);
        start = 1'b1; base_addr = 8'd20; len = 9'd8;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort_drv = 1'b1;
        @(negedge clk);
        abort_drv = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_rd_en", 32'(rd_en), 0);
        check("ab_mac_en", 32'(mac_en), 0);
        check("ab_mac_clr", 32'(mac_clr), 0);
        check("ab_done", 32'(done), 0);
        check("ab_result", 32'(result), 32'(exp_result));
        check_quiet(12);
        // Abort while IDLE does not block a start in the same cycle
        abort_drv = 1'b1;
        run_job(33, 4, 1'b0);
`endif

        // Full-depth length and randomized jobs
        fill_random();
        run_job(17, 256, 1'b0);
        for (int k = 0; k < 10; k++) begin
            fill_random();
            run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 24)), 1'b0);
        end
        check_quiet(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
